fixed_point_multiplier: RTL and testbench

Sequential unsigned fixed-point multiplier in Q4.6 format; the inverse-operation companion to the fixed-point divider. Operands are loaded into A/B holding registers and multiplied by a shift-add datapath, one multiplier bit per cycle. The result is truncated to Q4.6 and reported with an overflow flag. It sits beside the divider and uses the same load/start control style.

---
 rtl/fixed_point_pkg.sv | 19 +
 rtl/fixed_point_multiplier_if.sv | 29 ++
 rtl/fixed_point_multiplier_iter_counter.sv | 30 +++
 rtl/fixed_point_multiplier.sv | 130 +++++++++++++
 tb/tb_fixed_point_multiplier.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point multiplier and divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default Q4.6 geometry, iteration count, FSM state encoding.
package fixed_point_pkg;

  localparam int DEFAULT_WIDTH = 10;
  localparam int DEFAULT_FRAC  = 6;

  // One shift-add (or shift-subtract) step per operand bit.
  localparam int ITER = DEFAULT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fixed_point_multiplier_if.sv
// Operand/control/result bundle for the fixed-point multiplier.
// Latency: n/a (wiring only).
// Backpressure: none; start is ignored while busy, results are held until the next done.
// master drives start/ld_a/ld_b/A/B and observes q/ov/busy/done; slave is the multiplier side.
interface fixed_point_multiplier_if #(
  parameter int WIDTH = fixed_point_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic             ld_a;
  logic             ld_b;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] q;
  logic             ov;
  logic             busy;
  logic             done;

  modport master (
    output start, ld_a, ld_b, A, B,
    input  q, ov, busy, done
  );

  modport slave (
    input  start, ld_a, ld_b, A, B,
    output q, ov, busy, done
  );

endinterface

// File: rtl/fixed_point_multiplier_iter_counter.sv
// Mod-ITER up-counter that paces the iterative datapath.
// Latency: count updates one cycle after en; tc is combinational from the count.
// Backpressure: none; en simply holds the count when low.
// Ports: clk, rst (sync, active-high), clr (sync clear), en (advance), tc (count == ITER-1).
module iter_counter #(
  parameter int ITER = fixed_point_pkg::ITER
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/fixed_point_multiplier.sv
// Sequential unsigned Q4.6 multiplier: shift-add, one multiplier bit per cycle, truncated result + overflow.
// Latency: done pulses 11 cycles after the edge that samples start; one result per 12 cycles back-to-back.
// Backpressure: start is only honoured in IDLE (busy low); it is dropped, not queued, otherwise.
// Ports: clk, rst (sync, active-high), io (slave: start/ld_a/ld_b/A/B in, q/ov/busy/done out).
module fixed_point_multiplier
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int FRAC  = DEFAULT_FRAC
) (
  input logic                     clk,
  input logic                     rst,
  fixed_point_multiplier_if.slave io
);

  localparam int N_ITER = WIDTH;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mq;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH-1:0] q_r;
  logic             ov_r;
  logic             done_r;

  logic             cnt_clr;
  logic             cnt_en;
  logic             last_iter;

  iter_counter #(
    .ITER (N_ITER)
  ) u_iter_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (last_iter)
  );

  // Conditional add of the multiplicand; the 11th bit keeps the carry so the
  // following right shift moves it into the top of the accumulator.
  always_comb begin
    acc_sum = acc;
    if (mq[0]) begin
      acc_sum = {1'b0, acc[WIDTH-1:0]} + {1'b0, mcand};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (io.start) begin
          state_nxt = CALC;
          cnt_clr   = 1'b1;
        end
      end
      CALC: begin
        cnt_en = 1'b1;
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      mcand  <= '0;
      mq     <= '0;
      acc    <= '0;
      q_r    <= '0;
      ov_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= 1'b0;

      // Holding registers load in any state; a running operation works on
      // its own snapshot (mcand/mq), so these never disturb it.
      if (io.ld_a) a_reg <= io.A;
      if (io.ld_b) b_reg <= io.B;

      case (state)
        IDLE: begin
          if (io.start) begin
            mcand <= a_reg;
            mq    <= b_reg;
            acc   <= '0;
          end
        end
        CALC: begin
          acc <= {1'b0, acc_sum[WIDTH:1]};
          mq  <= {acc_sum[0], mq[WIDTH-1:1]};
        end
        DONE: begin
          // Product P = {acc[WIDTH-1:0], mq}. The Q4.6 result is
          // P[WIDTH+FRAC-1:FRAC], i.e. the low FRAC bits of acc over the high
          // bits of mq; anything above that in acc is integer overflow.
          q_r    <= {acc[FRAC-1:0], mq[WIDTH-1:FRAC]};
          ov_r   <= |acc[WIDTH-1:FRAC];
          done_r <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign io.q    = q_r;
  assign io.ov   = ov_r;
  assign io.done = done_r;
  assign io.busy = (state != IDLE);

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Self-checking bench for fixed_point_multiplier: vector table, random products, control races.
// Latency: expects done exactly 11 cycles after the start edge and busy high for 11 cycles.
// Backpressure: expected results queue at start and are popped on each done.
module tb_fixed_point_multiplier;

  typedef struct packed {
    logic [9:0] q;
    logic       ov;
  } res_t;

  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] q;
    logic       ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fixed_point_multiplier_if ifc ();

  fixed_point_multiplier dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  res_t       exp_q[$];
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         cyc       = 0;
  int         start_cyc = 0;
  int         busy_run  = 0;
  int         done_cnt  = 0;
  logic [9:0] a_sh = '0;
  logic [9:0] b_sh = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [9:0] a, input logic [9:0] b);
    logic [19:0] p;
    res_t        r;
    p    = 20'(a) * 20'(b);
    r.q  = p[15:6];
    r.ov = |p[19:16];
    return r;
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    res_t e;
    if (ifc.done === 1'b1) begin
      done_cnt++;
      chk("busy_len", busy_run, 11);
      chk("done_latency", cyc - start_cyc, 11);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: q=0x%0h ov=%0b, expected no done", ifc.q, ifc.ov);
      end else begin
        e = exp_q.pop_front();
        chk("q", int'(ifc.q), int'(e.q));
        chk("ov", int'(ifc.ov), int'(e.ov));
      end
    end
    if (ifc.busy === 1'b1) busy_run++;
    else busy_run = 0;
  end

  task automatic load(input logic [9:0] a, input logic [9:0] b);
    @(posedge clk); #1;
    ifc.A    = a;
    ifc.B    = b;
    ifc.ld_a = 1'b1;
    ifc.ld_b = 1'b1;
    a_sh     = a;
    b_sh     = b;
    @(posedge clk); #1;
    ifc.ld_a = 1'b0;
    ifc.ld_b = 1'b0;
  endtask

  // Raises start now; it is sampled at the next edge (edge 0).
  task automatic fire(input res_t e);
    ifc.start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    ifc.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (ifc.done === 1'b1);
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s_timeout: got no done, expected done within 40 cycles", name);
    end
  endtask

  vec_t tbl[9];
  int   dc;

  initial begin
    tbl[0] = '{10'h060, 10'h080, 10'h0C0, 1'b0};  // 1.5 x 2.0
    tbl[1] = '{10'h001, 10'h020, 10'h000, 1'b0};  // underflow truncates to 0
    tbl[2] = '{10'h200, 10'h080, 10'h000, 1'b1};  // 8.0 x 2.0 wraps
    tbl[3] = '{10'h3FF, 10'h3FF, 10'h3E0, 1'b1};  // max x max
    tbl[4] = '{10'h040, 10'h040, 10'h040, 1'b0};  // 1.0 x 1.0
    tbl[5] = '{10'h0FF, 10'h040, 10'h0FF, 1'b0};
    tbl[6] = '{10'h3FF, 10'h040, 10'h3FF, 1'b0};  // largest result without overflow
    tbl[7] = '{10'h3FF, 10'h041, 10'h00E, 1'b1};  // just over the top
    tbl[8] = '{10'h000, 10'h3FF, 10'h000, 1'b0};

    rst       = 1'b1;
    ifc.start = 1'b0;
    ifc.ld_a  = 1'b0;
    ifc.ld_b  = 1'b0;
    ifc.A     = '0;
    ifc.B     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_q", int'(ifc.q), 0);
    chk("rst_ov", int'(ifc.ov), 0);
    chk("rst_busy", int'(ifc.busy), 0);
    chk("rst_done", int'(ifc.done), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven vectors, each followed by a hold check on the result.
    for (int i = 0; i < 9; i++) begin
      load(tbl[i].a, tbl[i].b);
      fire('{q: tbl[i].q, ov: tbl[i].ov});
      wait_done("vec");
      repeat (2) @(negedge clk);
      chk("q_hold", int'(ifc.q), int'(tbl[i].q));
      chk("ov_hold", int'(ifc.ov), int'(tbl[i].ov));
      chk("done_pulse", int'(ifc.done), 0);
    end

    // Random operands against the arithmetic model.
    for (int i = 0; i < 6; i++) begin
      load(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
      fire(model(a_sh, b_sh));
      wait_done("rand");
    end

    // Load and start during CALC must not disturb the running operation.
    load(10'h040, 10'h0C0);
    fire(model(10'h040, 10'h0C0));
    repeat (3) @(posedge clk); #1;
    ifc.A     = 10'h3FF;
    ifc.ld_a  = 1'b1;
    ifc.start = 1'b1;
    a_sh      = 10'h3FF;
    @(posedge clk); #1;
    ifc.ld_a  = 1'b0;
    ifc.start = 1'b0;
    wait_done("race");
    @(negedge clk);
    dc = done_cnt;
    repeat (15) @(negedge clk);
    chk("race_extra_done", done_cnt - dc, 0);
    fire(model(a_sh, b_sh));
    wait_done("race_next");

    // Reset during CALC cycle 5 aborts without a done.
    load(10'h060, 10'h080);
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(ifc.busy), 0);
    chk("abort_done", int'(ifc.done), 0);
    chk("abort_q", int'(ifc.q), 0);
    chk("abort_ov", int'(ifc.ov), 0);
    dc = done_cnt;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 0);
    load(10'h040, 10'h040);
    fire(model(10'h040, 10'h040));
    wait_done("after_abort");

    // Reset and start on the same edge: reset wins.
    @(posedge clk); #1;
    rst       = 1'b1;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    ifc.start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", int'(ifc.busy), 0);
    dc = done_cnt;
    repeat (15) @(negedge clk);
    chk("rst_start_no_done", done_cnt - dc, 0);

    // Back-to-back: next start raised while done is high.
    load(10'h060, 10'h080);
    fire(model(10'h060, 10'h080));
    repeat (2) @(posedge clk);
    load(10'h3FF, 10'h3FF);
    wait_done("b2b_first");
    fire(model(a_sh, b_sh));
    wait_done("b2b_second");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
